// File: rtl/ffdiv_result_fifo.sv
// ffdiv_result_fifo: result stage behind the 32-bit float divider.
// Packs each divider result into an IEEE-754 single word and classifies it.
// Word and class flags are queued in a small FIFO that a valid/ready consumer drains.
// Optional feature macro: FFDIV_LAT_CNT_EN adds a per-entry start-to-result latency (res_lat).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   div_start                      divider start strobe (restarts latency count)
//   sign, biased_exp, fraction     divider result fields
//   div_ready                      divider result valid (level; rising edge pushes)
//   res_valid, res_ready           head handshake toward the consumer
//   res_data, res_flags            head word and {nan,inf,zero,denorm}, zero when not valid
//   fifo_level                     occupied entries, 0..FIFO_DEPTH
//   ovf_err, clr_err               sticky overflow flag and its synchronous clear
//   res_lat                        (FFDIV_LAT_CNT_EN only) head latency in cycles, saturating
module ffdiv_result_fifo #(
  parameter int unsigned OPERAND_WIDTH     = 32,
  parameter int unsigned EXP_WIDTH         = 8,
  parameter int unsigned SIGNIFICAND_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            div_start,
  input  logic                            sign,
  input  logic [EXP_WIDTH-1:0]            biased_exp,
  input  logic [SIGNIFICAND_WIDTH-2:0]    fraction,
  input  logic                            div_ready,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [OPERAND_WIDTH-1:0]        res_data,
  output logic [3:0]                      res_flags,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
`ifdef FFDIV_LAT_CNT_EN
  output logic [15:0]                     res_lat,
`endif
  output logic                            ovf_err,
  input  logic                            clr_err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned FLAG_W = 4;
`ifdef FFDIV_LAT_CNT_EN
  localparam int unsigned LAT_W   = 16;
  localparam int unsigned ENTRY_W = LAT_W + FLAG_W + OPERAND_WIDTH;
`else
  localparam int unsigned ENTRY_W = FLAG_W + OPERAND_WIDTH;
`endif

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_count;
  logic               r_valid;
  logic [ENTRY_W-1:0] r_head;
  logic               r_ovf;
  logic               r_rdy_q;
  logic               r_armed;

  logic               w_edge;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [LVL_W-1:0]   w_cnt_nxt;
  logic [PTR_W-1:0]   w_rd_nxt;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head_nxt;
  logic [FLAG_W-1:0]  w_flags;
  logic               w_exp_ones;
  logic               w_exp_zero;
  logic               w_frac_zero;

  // Result classification
  assign w_exp_ones  = &biased_exp;
  assign w_exp_zero  = ~|biased_exp;
  assign w_frac_zero = ~|fraction;
  assign w_flags     = {w_exp_ones & ~w_frac_zero, w_exp_ones & w_frac_zero,
                        w_exp_zero & w_frac_zero,  w_exp_zero & ~w_frac_zero};

`ifdef FFDIV_LAT_CNT_EN
  logic [LAT_W-1:0] r_lat_cnt;
  logic             r_counting;
  logic [LAT_W-1:0] w_lat_inc;
  logic [LAT_W-1:0] w_lat_val;

  assign w_lat_inc = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + LAT_W'(1);
  // The stored value includes the push cycle itself, so start->edge distance is reported
  assign w_lat_val = div_start ? '0 : w_lat_inc;
  assign w_entry   = {w_lat_val, w_flags, OPERAND_WIDTH'({sign, biased_exp, fraction})};

  // Latency counter: restarts on div_start, frozen after the result edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt  <= '0;
      r_counting <= 1'b0;
    end else if (div_start) begin
      r_lat_cnt  <= '0;
      r_counting <= 1'b1;
    end else if (w_edge) begin
      r_counting <= 1'b0;
    end else if (r_counting) begin
      r_lat_cnt  <= w_lat_inc;
    end
  end

  assign res_lat = r_head[ENTRY_W-1 -: LAT_W];
`else
  assign w_entry = {w_flags, OPERAND_WIDTH'({sign, biased_exp, fraction})};
`endif

  // r_armed blocks the first cycle after reset so an already-high div_ready is not an edge
  assign w_edge = div_ready & ~r_rdy_q & r_armed;
  assign w_full = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_pop  = r_valid & res_ready;
  assign w_push = w_edge & (~w_full | w_pop);
  assign w_drop = w_edge & w_full & ~w_pop;

  assign w_rd_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  // Occupancy update
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_count - LVL_W'(1);
    end
  end

  // Next head: a push landing in the slot the read pointer moves to bypasses the memory
  assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? w_entry : r_mem[w_rd_nxt];

  // FIFO storage, pointers and registered head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
      r_ovf    <= 1'b0;
      r_rdy_q  <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      r_head   <= (w_cnt_nxt != '0) ? w_head_nxt : '0;
      r_rdy_q  <= div_ready;
      r_armed  <= 1'b1;
      // Set has priority over clear
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign res_valid  = r_valid;
  assign res_data   = r_head[OPERAND_WIDTH-1:0];
  assign res_flags  = r_head[OPERAND_WIDTH +: FLAG_W];
  assign fifo_level = r_count;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_ffdiv_result_fifo.sv
module tb_ffdiv_result_fifo;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_start = 1'b0;
  logic        sign = 1'b0;
  logic [7:0]  biased_exp = '0;
  logic [22:0] fraction = '0;
  logic        div_ready = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic [2:0]  fifo_level;
  logic        ovf_err;
  logic        clr_err = 1'b0;
`ifdef FFDIV_LAT_CNT_EN
  logic [15:0] res_lat;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic exp_ovf = 1'b0;

  ffdiv_result_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_start  (div_start),
    .sign       (sign),
    .biased_exp (biased_exp),
    .fraction   (fraction),
    .div_ready  (div_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .fifo_level (fifo_level),
`ifdef FFDIV_LAT_CNT_EN
    .res_lat    (res_lat),
`endif
    .ovf_err    (ovf_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One divide: div_ready high one cycle, low one cycle; scoreboard mirrors FIFO capacity
  task automatic do_push(input logic s, input logic [7:0] e, input logic [22:0] f,
                         input logic [3:0] fl);
    exp_t item;
    sign = s; biased_exp = e; fraction = f;
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    item.data  = {s, e, f};
    item.flags = fl;
    if (sb.size() < 4) sb.push_back(item);
    else exp_ovf = 1'b1;
    tick();
  endtask

  // Compare head against scoreboard front, then accept it
  task automatic pop_check(input string tag);
    exp_t item;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty observed_valid=%0b expected=entry", tag, res_valid);
    end else begin
      item = sb.pop_front();
      check({tag, "_valid"}, 64'(res_valid), 64'(1));
      check({tag, "_data"},  64'(res_data),  64'(item.data));
      check({tag, "_flags"}, 64'(res_flags), 64'(item.flags));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_data",  64'(res_data),  64'(0));
    check("rst_flags", 64'(res_flags), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_ovf",   64'(ovf_err),   64'(0));
    rst_n = 1'b1;
    tick(); tick();

    // Single push, level held: one entry only, one-cycle latency
    sign = 1'b0; biased_exp = 8'h80; fraction = 23'h400000;
    div_ready = 1'b1;
    tick();
    check("t1_valid", 64'(res_valid),  64'(1));
    check("t1_data",  64'(res_data),   64'h40400000);
    check("t1_flags", 64'(res_flags),  64'(0));
    check("t1_level", 64'(fifo_level), 64'(1));
    repeat (4) tick();
    check("t1_hold_level", 64'(fifo_level), 64'(1));
    check("t1_hold_data",  64'(res_data),   64'h40400000);
    div_ready = 1'b0;
    tick();
    sb.push_back(exp_t'{data: 32'h40400000, flags: 4'b0000});
    pop_check("t1_pop");
    check("t1_empty_valid", 64'(res_valid),  64'(0));
    check("t1_empty_data",  64'(res_data),   64'(0));
    check("t1_empty_level", 64'(fifo_level), 64'(0));

    // Classification
    do_push(1'b0, 8'hFF, 23'h000000, 4'b0100);
    do_push(1'b0, 8'hFF, 23'h000001, 4'b1000);
    do_push(1'b1, 8'h00, 23'h000000, 4'b0010);
    do_push(1'b0, 8'h00, 23'h000100, 4'b0001);
    check("t3_level", 64'(fifo_level), 64'(4));
    check("t3_ovf",   64'(ovf_err),    64'(0));
    for (int i = 0; i < 4; i++) pop_check("t3_pop");
    check("t3_level_end", 64'(fifo_level), 64'(0));

    // Overflow: fifth push dropped, sticky flag, clear
    do_push(1'b0, 8'h7F, 23'h000000, 4'b0000);
    do_push(1'b1, 8'h81, 23'h200000, 4'b0000);
    do_push(1'b0, 8'h01, 23'h7FFFFF, 4'b0000);
    do_push(1'b1, 8'hFE, 23'h123456, 4'b0000);
    do_push(1'b0, 8'h90, 23'h000001, 4'b0000);
    check("t2_level", 64'(fifo_level), 64'(4));
    check("t2_ovf",   64'(ovf_err),    64'(exp_ovf));
    check("t2_ovf_lit", 64'(ovf_err),  64'(1));
    tick(); tick();
    check("t2_stable_data", 64'(res_data), 64'h3F800000);
    for (int i = 0; i < 4; i++) pop_check("t2_pop");
    check("t2_level_end", 64'(fifo_level), 64'(0));
    check("t2_ovf_sticky", 64'(ovf_err), 64'(1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_ovf = 1'b0;
    check("t2_ovf_clr", 64'(ovf_err), 64'(0));

    // Full with simultaneous push and pop
    do_push(1'b0, 8'h10, 23'h000011, 4'b0000);
    do_push(1'b0, 8'h20, 23'h000022, 4'b0000);
    do_push(1'b0, 8'h30, 23'h000033, 4'b0000);
    do_push(1'b0, 8'h40, 23'h000044, 4'b0000);
    check("t4_full", 64'(fifo_level), 64'(4));
    check("t4_head", 64'(res_data), 64'(sb[0].data));
    sign = 1'b1; biased_exp = 8'h50; fraction = 23'h000055;
    div_ready = 1'b1;
    res_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    res_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(exp_t'{data: {1'b1, 8'h50, 23'h000055}, flags: 4'b0000});
    check("t4_level", 64'(fifo_level), 64'(4));
    check("t4_ovf",   64'(ovf_err),    64'(0));
    tick();
    for (int i = 0; i < 4; i++) pop_check("t4_pop");
    check("t4_level_end", 64'(fifo_level), 64'(0));

    // Empty with push and ready in the same cycle: push kept
    sign = 1'b0; biased_exp = 8'h77; fraction = 23'h000777;
    div_ready = 1'b1;
    res_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    res_ready = 1'b0;
    sb.push_back(exp_t'{data: {1'b0, 8'h77, 23'h000777}, flags: 4'b0000});
    check("ep_level", 64'(fifo_level), 64'(1));
    tick();
    pop_check("ep_pop");

`ifdef FFDIV_LAT_CNT_EN
    // Latency: start sampled at edge 0, result edge sampled at edge 12
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (11) tick();
    sb.push_back(exp_t'{data: {1'b0, 8'h80, 23'h0}, flags: 4'b0000});
    sign = 1'b0; biased_exp = 8'h80; fraction = 23'h0;
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    check("t5_lat", 64'(res_lat), 64'(12));
    tick();
    pop_check("t5_pop");
    check("t5_lat_idle", 64'(res_lat), 64'(0));
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (70000) tick();
    sb.push_back(exp_t'{data: {1'b0, 8'h80, 23'h0}, flags: 4'b0000});
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    check("t5_lat_sat", 64'(res_lat), 64'hFFFF);
    tick();
    pop_check("t5_pop_sat");
`endif

    // Async reset with entries, release while div_ready high
    do_push(1'b0, 8'h01, 23'h1, 4'b0000);
    do_push(1'b0, 8'h02, 23'h2, 4'b0000);
    do_push(1'b0, 8'h03, 23'h3, 4'b0000);
    check("t6_pre_level", 64'(fifo_level), 64'(3));
    div_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(res_valid),  64'(0));
    check("t6_rst_level", 64'(fifo_level), 64'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_rel_valid", 64'(res_valid),  64'(0));
    check("t6_rel_level", 64'(fifo_level), 64'(0));
    div_ready = 1'b0;
    tick();
    check("t6_fall_level", 64'(fifo_level), 64'(0));
    sign = 1'b1; biased_exp = 8'h33; fraction = 23'h000333;
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    sb.push_back(exp_t'{data: {1'b1, 8'h33, 23'h000333}, flags: 4'b0000});
    check("t6_repush_level", 64'(fifo_level), 64'(1));
    tick();
    pop_check("t6_pop");
    check("t6_end_level", 64'(fifo_level), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
